// File: rtl/dma_lite_sequencer.sv
// AXI-Lite master that programs an AXI DMA MM2S channel (DMACR, SA, LENGTH)
// and then polls DMASR until the channel goes idle, reports an error, or times out.
module dma_lite_sequencer #(
  parameter int POLL_GAP   = 16,
  parameter int POLL_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [25:0] xfer_len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] last_status,
  output logic [9:0]  m_axi_lite_awaddr,
  output logic        m_axi_lite_awvalid,
  input  logic        m_axi_lite_awready,
  output logic [31:0] m_axi_lite_wdata,
  output logic [3:0]  m_axi_lite_wstrb,
  output logic        m_axi_lite_wvalid,
  input  logic        m_axi_lite_wready,
  input  logic [1:0]  m_axi_lite_bresp,
  input  logic        m_axi_lite_bvalid,
  output logic        m_axi_lite_bready,
  output logic [9:0]  m_axi_lite_araddr,
  output logic        m_axi_lite_arvalid,
  input  logic        m_axi_lite_arready,
  input  logic [31:0] m_axi_lite_rdata,
  input  logic [1:0]  m_axi_lite_rresp,
  input  logic        m_axi_lite_rvalid,
  output logic        m_axi_lite_rready
);

  typedef enum logic [8:0] {
    IDLE      = 9'b000000001,
    WR_REQ    = 9'b000000010,
    WR_RESP   = 9'b000000100,
    NEXT_WR   = 9'b000001000,
    RD_REQ    = 9'b000010000,
    RD_RESP   = 9'b000100000,
    POLL_WAIT = 9'b001000000,
    DONE      = 9'b010000000,
    ERROR     = 9'b100000000
  } state_t;

  localparam logic [9:0]  DMASR_ADDR   = 10'h004;
  localparam logic [16:0] POLL_LIMIT_L = 17'(POLL_LIMIT);
  localparam logic [7:0]  GAP_LAST     = 8'(POLL_GAP - 1);

  localparam logic [1:0] ERR_BRESP   = 2'b01;
  localparam logic [1:0] ERR_DMASR   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  function automatic logic [9:0] wr_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    wr_addr = 10'h000;
      2'd1:    wr_addr = 10'h018;
      default: wr_addr = 10'h028;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [1:0] idx, input logic [31:0] src,
                                          input logic [25:0] len);
    case (idx)
      2'd0:    wr_data = 32'h0000_0001;
      2'd1:    wr_data = src;
      default: wr_data = {6'b0, len};
    endcase
  endfunction

  state_t      state;
  logic [31:0] src_q;
  logic [25:0] len_q;
  logic [1:0]  wr_idx;
  logic [15:0] poll_cnt;
  logic [7:0]  gap_cnt;

  logic        aw_clear;
  logic        w_clear;
  logic [1:0]  wr_idx_next;
  logic [16:0] poll_next;
  logic        unused_rresp;

  // A channel is finished once its valid has dropped or it handshakes this cycle.
  assign aw_clear     = !m_axi_lite_awvalid || m_axi_lite_awready;
  assign w_clear      = !m_axi_lite_wvalid  || m_axi_lite_wready;
  assign wr_idx_next  = wr_idx + 2'd1;
  assign poll_next    = {1'b0, poll_cnt} + 17'd1;
  assign unused_rresp = ^m_axi_lite_rresp;

  assign m_axi_lite_wstrb = 4'hF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      src_q              <= '0;
      len_q              <= '0;
      wr_idx             <= '0;
      poll_cnt           <= '0;
      gap_cnt            <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      err_code           <= '0;
      last_status        <= '0;
      m_axi_lite_awaddr  <= '0;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wdata   <= '0;
      m_axi_lite_wvalid  <= 1'b0;
      m_axi_lite_bready  <= 1'b0;
      m_axi_lite_araddr  <= '0;
      m_axi_lite_arvalid <= 1'b0;
      m_axi_lite_rready  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state              <= WR_REQ;
            src_q              <= src_addr;
            len_q              <= xfer_len;
            err_code           <= '0;
            last_status        <= '0;
            wr_idx             <= '0;
            busy               <= 1'b1;
            m_axi_lite_awvalid <= 1'b1;
            m_axi_lite_wvalid  <= 1'b1;
            m_axi_lite_awaddr  <= wr_addr(2'd0);
            m_axi_lite_wdata   <= wr_data(2'd0, src_addr, xfer_len);
          end
        end
        WR_REQ: begin
          if (m_axi_lite_awvalid && m_axi_lite_awready) begin
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_awaddr  <= '0;
          end
          if (m_axi_lite_wvalid && m_axi_lite_wready) begin
            m_axi_lite_wvalid <= 1'b0;
            m_axi_lite_wdata  <= '0;
          end
          if (aw_clear && w_clear) begin
            state             <= WR_RESP;
            m_axi_lite_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi_lite_bvalid) begin
            m_axi_lite_bready <= 1'b0;
            if (m_axi_lite_bresp != 2'b00) begin
              state    <= ERROR;
              err_code <= ERR_BRESP;
              error    <= 1'b1;
            end else begin
              state <= NEXT_WR;
            end
          end
        end
        NEXT_WR: begin
          wr_idx <= wr_idx_next;
          if (wr_idx == 2'd2) begin
            state              <= RD_REQ;
            poll_cnt           <= '0;
            m_axi_lite_arvalid <= 1'b1;
            m_axi_lite_araddr  <= DMASR_ADDR;
          end else begin
            state              <= WR_REQ;
            m_axi_lite_awvalid <= 1'b1;
            m_axi_lite_wvalid  <= 1'b1;
            m_axi_lite_awaddr  <= wr_addr(wr_idx_next);
            m_axi_lite_wdata   <= wr_data(wr_idx_next, src_q, len_q);
          end
        end
        RD_REQ: begin
          if (m_axi_lite_arready) begin
            state              <= RD_RESP;
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_araddr  <= '0;
            m_axi_lite_rready  <= 1'b1;
          end
        end
        RD_RESP: begin
          // Error bits outrank Idle, and a clean Idle outranks the poll timeout.
          if (m_axi_lite_rvalid) begin
            m_axi_lite_rready <= 1'b0;
            last_status       <= m_axi_lite_rdata;
            poll_cnt          <= poll_next[15:0];
            if (|m_axi_lite_rdata[6:4]) begin
              state    <= ERROR;
              err_code <= ERR_DMASR;
              error    <= 1'b1;
            end else if (m_axi_lite_rdata[1]) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (poll_next == POLL_LIMIT_L) begin
              state    <= ERROR;
              err_code <= ERR_TIMEOUT;
              error    <= 1'b1;
            end else begin
              state   <= POLL_WAIT;
              gap_cnt <= '0;
            end
          end
        end
        POLL_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            state              <= RD_REQ;
            gap_cnt            <= '0;
            m_axi_lite_arvalid <= 1'b1;
            m_axi_lite_araddr  <= DMASR_ADDR;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERROR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state              <= IDLE;
          busy               <= 1'b0;
          m_axi_lite_awvalid <= 1'b0;
          m_axi_lite_wvalid  <= 1'b0;
          m_axi_lite_bready  <= 1'b0;
          m_axi_lite_arvalid <= 1'b0;
          m_axi_lite_rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_lite_sequencer.sv
// Directed bench for dma_lite_sequencer: a procedural AXI-Lite slave drives each
// transfer and every observed value is compared with hand-derived expectations.
module tb_dma_lite_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [25:0] xfer_len = '0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] last_status;
  logic [9:0]  awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [9:0]  araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int ar_cnt = 0;
  logic overlap = 1'b0;

  always #5 clk = ~clk;

  dma_lite_sequencer #(.POLL_GAP(2), .POLL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .xfer_len(xfer_len),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .last_status(last_status),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
    .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid),
    .m_axi_lite_bready(bready), .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid),
    .m_axi_lite_arready(arready), .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    if ((awvalid || wvalid || bready) && (arvalid || rready)) overlap <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] sa, input logic [25:0] ln);
    src_addr = sa;
    xfer_len = ln;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic serve_write(input string tag, input logic [9:0] ea, input logic [31:0] ed,
                             input int aw_dly, input int w_dly, input logic [1:0] resp);
    int n = 0;
    int last;
    while (!awvalid && n < 50) begin tick(); n++; end
    check({tag, "_awvalid"}, awvalid, 1);
    check({tag, "_wvalid"}, wvalid, 1);
    check({tag, "_awaddr"}, awaddr, ea);
    check({tag, "_wdata"}, wdata, ed);
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int k = 0; k <= last; k++) begin
      awready = (k == aw_dly);
      wready  = (k == w_dly);
      tick();
      check({tag, "_awvalid_hold"}, awvalid, (k < aw_dly));
      check({tag, "_wvalid_hold"}, wvalid, (k < w_dly));
      check({tag, "_bready"}, bready, (k == last));
    end
    awready = 1'b0;
    wready = 1'b0;
    check({tag, "_awaddr_idle"}, awaddr, 0);
    check({tag, "_wdata_idle"}, wdata, 0);
    bvalid = 1'b1;
    bresp = resp;
    tick();
    bvalid = 1'b0;
    bresp = 2'b00;
    check({tag, "_bready_drop"}, bready, 0);
  endtask

  task automatic serve_read(input string tag, input logic [31:0] rd, output int hs_cyc);
    int n = 0;
    while (!arvalid && n < 50) begin tick(); n++; end
    check({tag, "_arvalid"}, arvalid, 1);
    check({tag, "_araddr"}, araddr, 10'h004);
    arready = 1'b1;
    tick();
    hs_cyc = cyc;
    arready = 1'b0;
    check({tag, "_arvalid_drop"}, arvalid, 0);
    check({tag, "_araddr_idle"}, araddr, 0);
    check({tag, "_rready"}, rready, 1);
    rvalid = 1'b1;
    rdata = rd;
    tick();
    rvalid = 1'b0;
    rdata = '0;
    check({tag, "_rready_drop"}, rready, 0);
  endtask

  task automatic wait_end(input string tag, input logic exp_done, input logic exp_err);
    int n = 0;
    while (!done && !error && n < 40) begin tick(); n++; end
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy_end"}, busy, 1);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_error_pulse"}, error, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int hs[4];
    int aw0, w0, ar0;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, error}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_last_status", last_status, 0);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_addrs", {awaddr, araddr}, 0);
    check("rst_wdata", wdata, 0);
    check("wstrb", wstrb, 4'hF);
    rst = 1'b0;
    tick();

    // Clean run
    aw0 = aw_cnt; ar0 = ar_cnt;
    do_start(32'h1000_0000, 26'h400);
    check("clean_busy", busy, 1);
    serve_write("c_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b00);
    serve_write("c_w1", 10'h018, 32'h1000_0000, 0, 0, 2'b00);
    serve_write("c_w2", 10'h028, 32'h0000_0400, 0, 0, 2'b00);
    serve_read("c_r0", 32'h0, hs[0]);
    serve_read("c_r1", 32'h0, hs[0]);
    serve_read("c_r2", 32'h2, hs[0]);
    wait_end("clean", 1'b1, 1'b0);
    check("clean_last_status", last_status, 32'h2);
    check("clean_err_code", err_code, 0);
    check("clean_aw_count", aw_cnt - aw0, 3);
    check("clean_ar_count", ar_cnt - ar0, 3);

    // Skewed handshake on write 1
    aw0 = aw_cnt; w0 = w_cnt;
    do_start(32'h1000_0000, 26'h400);
    serve_write("s_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b00);
    serve_write("s_w1", 10'h018, 32'h1000_0000, 3, 0, 2'b00);
    serve_write("s_w2", 10'h028, 32'h0000_0400, 0, 0, 2'b00);
    serve_read("s_r0", 32'h2, hs[0]);
    wait_end("skew", 1'b1, 1'b0);
    check("skew_aw_count", aw_cnt - aw0, 3);
    check("skew_w_count", w_cnt - w0, 3);

    // Write response error on write 0
    aw0 = aw_cnt;
    do_start(32'h1000_0000, 26'h400);
    serve_write("e_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b10);
    check("werr_err_code_now", err_code, 2'b01);
    wait_end("werr", 1'b0, 1'b1);
    tick(); tick(); tick();
    check("werr_aw_count", aw_cnt - aw0, 1);
    check("werr_awvalid", awvalid, 0);
    check("werr_err_code_held", err_code, 2'b01);

    // DMASR error bits; start held high the whole time
    src_addr = 32'h1000_0000;
    xfer_len = 26'h400;
    start = 1'b1;
    tick();
    serve_write("d_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b00);
    serve_write("d_w1", 10'h018, 32'h1000_0000, 0, 0, 2'b00);
    serve_write("d_w2", 10'h028, 32'h0000_0400, 0, 0, 2'b00);
    serve_read("d_r0", 32'h0000_0011, hs[0]);
    check("dmasr_error", error, 1);
    check("dmasr_err_code", err_code, 2'b10);
    check("dmasr_last_status", last_status, 32'h11);
    tick();
    check("dmasr_idle_busy", busy, 0);
    tick();
    check("restart_busy", busy, 1);
    check("restart_awvalid", awvalid, 1);
    check("restart_err_code_clr", err_code, 0);
    check("restart_status_clr", last_status, 0);
    start = 1'b0;
    serve_write("r_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b00);
    serve_write("r_w1", 10'h018, 32'h1000_0000, 0, 0, 2'b00);
    serve_write("r_w2", 10'h028, 32'h0000_0400, 0, 0, 2'b00);
    serve_read("r_r0", 32'h2, hs[0]);
    wait_end("restart", 1'b1, 1'b0);

    // Poll timeout: limit 4, gap 2
    ar0 = ar_cnt;
    do_start(32'h1000_0000, 26'h400);
    serve_write("t_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b00);
    serve_write("t_w1", 10'h018, 32'h1000_0000, 0, 0, 2'b00);
    serve_write("t_w2", 10'h028, 32'h0000_0400, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) serve_read("t_r", 32'h0, hs[i]);
    check("timeout_err_code", err_code, 2'b11);
    wait_end("timeout", 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) check("timeout_gap", hs[i] - hs[i-1], 4);
    tick(); tick(); tick();
    check("timeout_ar_count", ar_cnt - ar0, 4);

    // Reset during POLL_WAIT, then a full new transfer
    aw0 = aw_cnt;
    do_start(32'h1000_0000, 26'h400);
    serve_write("p_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b00);
    serve_write("p_w1", 10'h018, 32'h1000_0000, 0, 0, 2'b00);
    serve_write("p_w2", 10'h028, 32'h0000_0400, 0, 0, 2'b00);
    serve_read("p_r0", 32'h0000_0001, hs[0]);
    check("midpoll_status", last_status, 32'h1);
    rst = 1'b1;
    tick();
    check("midpoll_busy", busy, 0);
    check("midpoll_pulses", {done, error}, 0);
    check("midpoll_status_rst", last_status, 0);
    check("midpoll_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("midpoll_quiet", {arvalid, busy}, 0);
    do_start(32'h1000_0000, 26'h400);
    serve_write("q_w0", 10'h000, 32'h0000_0001, 0, 0, 2'b00);
    serve_write("q_w1", 10'h018, 32'h1000_0000, 0, 0, 2'b00);
    serve_write("q_w2", 10'h028, 32'h0000_0400, 0, 0, 2'b00);
    serve_read("q_r0", 32'h2, hs[0]);
    wait_end("after_rst", 1'b1, 1'b0);
    check("after_rst_aw_count", aw_cnt - aw0, 6);

    check("no_rw_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_lite_sequencer.md
DMA_LITE_SEQUENCER -- requirements
Module: dma_lite_sequencer

Interface
REQ-001 Parameter POLL_GAP, default 16: idle cycles between consecutive status reads (1..255).
REQ-002 Parameter POLL_LIMIT, default 4096: maximum status reads before timeout (1..65535).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 src_addr  input  32  MM2S source address; captured on accepted start.
REQ-007 xfer_len  input  26  MM2S byte length; captured on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse: transfer completed cleanly.
REQ-010 error  output  1  one-cycle pulse: transfer aborted.
REQ-011 err_code  output  2  cause of the last error: 01 write BRESP, 10 DMASR error bits, 11 timeout; held until next accepted start.
REQ-012 last_status  output  32  last DMASR word read; held until next accepted start.
REQ-013 m_axi_lite_awaddr/awvalid/awready  10/1/1  AXI-Lite write address channel (out/out/in).
REQ-014 m_axi_lite_wdata/wstrb/wvalid/wready  32/4/1/1  write data channel (out/out/out/in); wstrb is always 4'hF.
REQ-015 m_axi_lite_bresp/bvalid/bready  2/1/1  write response channel (in/in/out).
REQ-016 m_axi_lite_araddr/arvalid/arready  10/1/1  read address channel (out/out/in).
REQ-017 m_axi_lite_rdata/rresp/rvalid/rready  32/2/1/1  read data channel (in/in/in/out).

Function
REQ-018 States: IDLE, WR_REQ, WR_RESP, NEXT_WR, RD_REQ, RD_RESP, POLL_WAIT, DONE, ERROR; one-hot encoding.
REQ-019 IDLE -> WR_REQ on start=1; src_addr and xfer_len are registered; err_code is cleared to 0; last_status is cleared to 0; the write index is set to 0.
REQ-020 Write sequence by index: 0: addr 0x00 data 0x0000_0001 (DMACR RS); 1: addr 0x18 data src_addr; 2: addr 0x28 data {6'b0,xfer_len}.
REQ-021 WR_REQ: awvalid and wvalid assert together from the first cycle in the state, with addr and data stable.
  - awvalid drops the cycle after awready is sampled high; wvalid drops the cycle after wready is sampled high; the two channels are independent.
  - The block moves to WR_RESP when both handshakes have completed, whether they complete in the same cycle or in any order.
REQ-022 WR_RESP: bready=1; on bvalid: if bresp!=00 the block goes to ERROR with err_code=01; otherwise it goes to NEXT_WR.
REQ-023 NEXT_WR: the block increments the index; if the index was 2 it goes to RD_REQ and clears the poll counter; otherwise it goes to WR_REQ.
REQ-024 RD_REQ: araddr=0x04 and arvalid=1 until arready is sampled high, then the block goes to RD_RESP; arvalid holds until the handshake.
REQ-025 RD_RESP: rready=1; on rvalid, rdata is captured into last_status and the poll counter increments.
REQ-026 RD_RESP priority on the read word (rresp is ignored):
  1. rdata[6:4]!=0 -> ERROR, err_code=10.
  2. rdata[1]=1 (Idle) -> DONE.
  3. Poll counter reaches POLL_LIMIT -> ERROR, err_code=11.
  4. Otherwise -> POLL_WAIT.
REQ-027 POLL_WAIT: counts POLL_GAP cycles, then goes to RD_REQ.
REQ-028 DONE: done=1 for one cycle, then IDLE; ERROR: error=1 for one cycle, then IDLE.
REQ-029 start is ignored outside IDLE; start held high in IDLE after DONE/ERROR begins a new transfer on the next cycle.
REQ-030 No more than one AXI-Lite transaction is outstanding at any time; write and read channels are never active simultaneously.
REQ-031 All AXI valid and ready outputs are registered; addresses and data are 0 when the matching valid is low.
REQ-032 An AXI-Lite handshake is a cycle with valid and ready both high; the block accepts ready asserted before valid.

Reset
REQ-033 On rst: state=IDLE, and all valid/ready outputs, busy, done, error are 0, and err_code=0, last_status=0, all counters=0.
REQ-034 rst asserted mid-transaction aborts immediately, with no done/error pulse; slave-side recovery is outside this block.

Verification
REQ-035 Clean run: start with src_addr=0x1000_0000, xfer_len=0x400; slave ready same cycle; DMASR returns 0x0, 0x0, 0x2.
  - Required: writes (0x00,0x1), (0x18,0x1000_0000), (0x28,0x400); three reads at 0x04; done pulse; last_status=0x2.
REQ-036 Skewed handshake: wready 3 cycles before awready on write 1 -> wvalid drops first; a single write of 0x1000_0000 to 0x18 follows; the sequence continues.
REQ-037 Write error: bresp=10 on write 0 -> no further AW; error pulse; err_code=01; busy low 2 cycles after the BRESP.
REQ-038 DMASR error: read returns 0x0000_0011 (bit4 set) -> error pulse; err_code=10; last_status=0x11.
REQ-039 Timeout: POLL_LIMIT=4, POLL_GAP=2, DMASR always 0x0 -> exactly 4 reads, each ≥2 cycles apart; error pulse; err_code=11.
REQ-040 Reset mid-poll: rst during POLL_WAIT -> all outputs at reset values the next cycle; a later start repeats the full write sequence.
